// File: rtl/mem_pkg.sv
// Shared constants and types for the data-memory responder.
//   F3_*        : RV32I funct3 encodings for load/store sizing
//   mem_state_t : responder FSM states
package mem_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

endpackage

// File: rtl/load_store_align.sv
// Combinational RV32I sizing/lane logic for one access.
//   we, funct3, addr_lo : access description (addr_lo = addr[1:0])
//   wdata               : right-aligned store data
//   rword               : addressed RAM word
//   be_c                : byte enables for a store (0 when bad_c)
//   wdata_lane_c        : store data replicated into every lane
//   rdata_ext_c         : lane-selected, sign/zero-extended load data
//   bad_c               : illegal funct3 or misaligned address
module load_store_align
    import mem_pkg::*;
(
    input  logic            we,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rword,
    output logic [3:0]      be_c,
    output logic [XLEN-1:0] wdata_lane_c,
    output logic [XLEN-1:0] rdata_ext_c,
    output logic            bad_c
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic        illegal;
    logic        misaligned;

    // Size decode, lane steering and extension
    always_comb begin
        be_c         = 4'b0000;
        wdata_lane_c = '0;
        rdata_ext_c  = '0;
        illegal      = 1'b0;
        misaligned   = 1'b0;
        rbyte        = rword[{addr_lo, 3'b000} +: 8];
        rhalf        = addr_lo[1] ? rword[31:16] : rword[15:0];

        case (funct3)
            F3_B: begin
                be_c         = 4'b0001 << addr_lo;
                wdata_lane_c = {4{wdata[7:0]}};
                rdata_ext_c  = {{24{rbyte[7]}}, rbyte};
            end
            F3_H: begin
                be_c         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane_c = {2{wdata[15:0]}};
                rdata_ext_c  = {{16{rhalf[15]}}, rhalf};
                misaligned   = addr_lo[0];
            end
            F3_W: begin
                be_c         = 4'b1111;
                wdata_lane_c = wdata;
                rdata_ext_c  = rword;
                misaligned   = (addr_lo != 2'b00);
            end
            F3_BU: begin
                rdata_ext_c  = {24'h0, rbyte};
                illegal      = we;
            end
            F3_HU: begin
                rdata_ext_c  = {16'h0, rhalf};
                misaligned   = addr_lo[0];
                illegal      = we;
            end
            default: illegal = 1'b1;
        endcase

        bad_c = illegal | misaligned;
        if (bad_c) begin
            be_c = 4'b0000;
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Responder for the MEM-stage data-memory port: word RAM with wait states.
//   clk, reset : clock and synchronous active-high reset
//   req        : load/store request, held with we/funct3/addr/wdata until done
//   rdata      : extended load data, registered on the commit edge
//   done       : one-cycle completion pulse
//   fault      : with done, misaligned or illegal access (no memory effect)
//   stall      : combinational req & ~done for the hazard unit
//   busy       : FSM not idle
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req,
    input  logic            we,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata,
    output logic            done,
    output logic            fault,
    output logic            stall,
    output logic            busy
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    mem_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [IDX_W+1:0]  addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              done_q, done_d;
    logic              fault_q, fault_d;
    logic              busy_q, busy_d;

    logic [XLEN-1:0]   mem_q [DEPTH_WORDS];

    logic              sel_we;
    logic [2:0]        sel_funct3;
    logic [IDX_W+1:0]  sel_addr;
    logic [XLEN-1:0]   sel_wdata;
    logic [IDX_W-1:0]  idx;
    logic [3:0]        be_c;
    logic [XLEN-1:0]   wdata_lane_c;
    logic [XLEN-1:0]   rdata_ext_c;
    logic              bad_c;
    logic              commit_c;
    logic              mem_wr_c;
    logic              unused_addr_c;

    // Upper address bits alias onto the RAM
    assign unused_addr_c = ^addr[XLEN-1:IDX_W+2];

    // In IDLE the live request is used so a zero-wait access commits on the accept edge
    always_comb begin
        sel_we     = we_q;
        sel_funct3 = funct3_q;
        sel_addr   = addr_q;
        sel_wdata  = wdata_q;
        if (state_q == IDLE) begin
            sel_we     = we;
            sel_funct3 = funct3;
            sel_addr   = addr[IDX_W+1:0];
            sel_wdata  = wdata;
        end
    end

    assign idx = sel_addr[IDX_W+1:2];

    load_store_align u_align (
        .we           (sel_we),
        .funct3       (sel_funct3),
        .addr_lo      (sel_addr[1:0]),
        .wdata        (sel_wdata),
        .rword        (mem_q[idx]),
        .be_c         (be_c),
        .wdata_lane_c (wdata_lane_c),
        .rdata_ext_c  (rdata_ext_c),
        .bad_c        (bad_c)
    );

    // Next-state and output logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        done_d   = 1'b0;
        fault_d  = 1'b0;
        commit_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    we_d     = we;
                    funct3_d = funct3;
                    addr_d   = addr[IDX_W+1:0];
                    wdata_d  = wdata;
                    if (bad_c) begin
                        state_d = RESP;
                        done_d  = 1'b1;
                        fault_d = 1'b1;
                        rdata_d = '0;
                    end else if (WAIT_STATES == 0) begin
                        commit_c = 1'b1;
                        state_d  = RESP;
                        done_d   = 1'b1;
                    end else begin
                        cnt_d   = CNT_W'(WAIT_STATES - 1);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    commit_c = 1'b1;
                    state_d  = RESP;
                    done_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (commit_c && !sel_we) begin
            rdata_d = rdata_ext_c;
        end
        busy_d = (state_d != IDLE);
    end

    // Reset wins over a store committing on the same edge
    assign mem_wr_c = commit_c & sel_we & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            done_q   <= 1'b0;
            fault_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            done_q   <= done_d;
            fault_q  <= fault_d;
            busy_q   <= busy_d;
        end
    end

    // Byte-lane RAM write; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_wr_c) begin
            for (int b = 0; b < 4; b++) begin
                if (be_c[b]) begin
                    mem_q[idx][8*b +: 8] <= wdata_lane_c[8*b +: 8];
                end
            end
        end
    end

    assign rdata = rdata_q;
    assign done  = done_q;
    assign fault = fault_q;
    assign busy  = busy_q;
    assign stall = req & ~done_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a 2-wait-state and a 0-wait-state instance
// checked against a byte-addressed memory model.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req2;
    logic        we_i;
    logic [2:0]  f3_i;
    logic [31:0] addr_i, wdata_i;
    logic [31:0] rdata0, rdata2;
    logic        done0, done2, fault0, fault2, stall0, stall2, busy0, busy2;

    int checks = 0;
    int errors = 0;

    // ref_mem[0] models the 0-wait instance, ref_mem[1] the 2-wait instance
    logic [7:0] ref_mem [2][4096];

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .req(req0), .we(we_i), .funct3(f3_i),
        .addr(addr_i), .wdata(wdata_i), .rdata(rdata0), .done(done0),
        .fault(fault0), .stall(stall0), .busy(busy0)
    );

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) dut2 (
        .clk(clk), .reset(reset), .req(req2), .we(we_i), .funct3(f3_i),
        .addr(addr_i), .wdata(wdata_i), .rdata(rdata2), .done(done2),
        .fault(fault2), .stall(stall2), .busy(busy2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int acc_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit model_bad(input bit w, input logic [2:0] f3, input logic [31:0] a);
        bit legal;
        legal = w ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal) return 1'b1;
        return (a % acc_size(f3)) != 0;
    endfunction

    function automatic logic [31:0] model_load(input int s, input logic [2:0] f3, input logic [31:0] a);
        int n;
        logic [31:0] v;
        n = acc_size(f3);
        v = 32'h0;
        for (int i = 0; i < n; i++)
            v = v | (32'(ref_mem[s][(a + 32'(i)) % 4096]) << (8 * i));
        if (!f3[2] && n < 4 && v[8*n-1])
            v = v | ~((32'h1 << (8 * n)) - 32'h1);
        return v;
    endfunction

    task automatic model_store(input int s, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        for (int i = 0; i < acc_size(f3); i++)
            ref_mem[s][(a + 32'(i)) % 4096] = 8'(d >> (8 * i));
    endtask

    function automatic logic get_done(input int s);  return s != 0 ? done2  : done0;  endfunction
    function automatic logic get_fault(input int s); return s != 0 ? fault2 : fault0; endfunction
    function automatic logic get_stall(input int s); return s != 0 ? stall2 : stall0; endfunction
    function automatic logic get_busy(input int s);  return s != 0 ? busy2  : busy0;  endfunction
    function automatic logic [31:0] get_rdata(input int s); return s != 0 ? rdata2 : rdata0; endfunction

    // Issue one request at a negedge, wait for done, check it; req is left high
    task automatic access(input int s, input bit w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input int exp_lat, output logic [31:0] rd);
        int  lat;
        bit  seen;
        bit  exp_f;
        logic [31:0] exp_rd;
        exp_f  = model_bad(w, f3, a);
        exp_rd = exp_f ? 32'h0 : model_load(s, f3, a);
        we_i = w; f3_i = f3; addr_i = a; wdata_i = d;
        if (s != 0) req2 = 1'b1; else req0 = 1'b1;
        lat = 0; seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (get_done(s)) seen = 1'b1;
            else chk("stall_while_pending", 32'(get_stall(s)), 32'd1);
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("fault", 32'(get_fault(s)), 32'(exp_f));
        if (!w || exp_f) chk("rdata", get_rdata(s), exp_rd);
        chk("stall_at_done", 32'(get_stall(s)), 32'd0);
        if (w && !exp_f) model_store(s, f3, a, d);
        rd = get_rdata(s);
    endtask

    task automatic idle(input int s);
        req0 = 1'b0; req2 = 1'b0;
        @(negedge clk);
        chk("busy_idle", 32'(get_busy(s)), 32'd0);
    endtask

    task automatic chk_reset_outputs(input int s);
        chk("rst_rdata", get_rdata(s), 32'h0);
        chk("rst_done",  32'(get_done(s)), 32'd0);
        chk("rst_fault", 32'(get_fault(s)), 32'd0);
        chk("rst_busy",  32'(get_busy(s)), 32'd0);
        chk("rst_stall", 32'(get_stall(s)), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        logic [2:0]  f3;
        bit          w;

        reset = 1'b1; req0 = 1'b0; req2 = 1'b0;
        we_i = 1'b0; f3_i = 3'b010; addr_i = '0; wdata_i = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_reset_outputs(0);
        chk_reset_outputs(1);

        // Give both RAMs known contents over the test window
        for (int i = 0; i < 16; i++) begin
            access(1, 1'b1, 3'b010, 32'(4 * i), $urandom, 3, rd);
            idle(1);
        end
        for (int i = 0; i < 16; i++)
            access(0, 1'b1, 3'b010, 32'(4 * i), $urandom, (i == 0) ? 1 : 2, rd);
        idle(0);

        // Reset during an in-flight store aborts it
        access(1, 1'b1, 3'b010, 32'h10, 32'h1111_1111, 3, rd);
        idle(1);
        we_i = 1'b1; f3_i = 3'b010; addr_i = 32'h10; wdata_i = 32'hDEAD_BEEF; req2 = 1'b1;
        @(negedge clk);
        reset = 1'b1; req2 = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("done_during_reset", 32'(done2), 32'd0);
        end
        reset = 1'b0;
        chk_reset_outputs(1);
        access(1, 1'b0, 3'b010, 32'h10, 32'h0, 3, rd);
        chk("aborted_store", rd, 32'h1111_1111);
        idle(1);

        // Latency, byte and halfword lanes
        access(1, 1'b1, 3'b010, 32'h20, 32'h1234_5678, 3, rd); idle(1);
        access(1, 1'b0, 3'b010, 32'h20, 32'h0, 3, rd);         idle(1);
        chk("lw_after_sw", rd, 32'h1234_5678);
        access(1, 1'b1, 3'b000, 32'h21, 32'hFFFF_FFAB, 3, rd); idle(1);
        access(1, 1'b1, 3'b001, 32'h22, 32'h0000_CDEF, 3, rd); idle(1);
        access(1, 1'b0, 3'b010, 32'h20, 32'h0, 3, rd);         idle(1);
        chk("lanes", rd, 32'hCDEF_AB78);

        // Sign and zero extension
        access(1, 1'b1, 3'b010, 32'h30, 32'h80FF_7F01, 3, rd); idle(1);
        access(1, 1'b0, 3'b000, 32'h32, 32'h0, 3, rd); idle(1); chk("lb_32",  rd, 32'hFFFF_FFFF);
        access(1, 1'b0, 3'b100, 32'h32, 32'h0, 3, rd); idle(1); chk("lbu_32", rd, 32'h0000_00FF);
        access(1, 1'b0, 3'b001, 32'h32, 32'h0, 3, rd); idle(1); chk("lh_32",  rd, 32'hFFFF_80FF);
        access(1, 1'b0, 3'b101, 32'h32, 32'h0, 3, rd); idle(1); chk("lhu_32", rd, 32'h0000_80FF);
        access(1, 1'b0, 3'b000, 32'h30, 32'h0, 3, rd); idle(1); chk("lb_30",  rd, 32'h0000_0001);

        // Faults respond after one cycle and leave RAM alone
        access(1, 1'b0, 3'b001, 32'h31, 32'h0, 1, rd);         idle(1);
        access(1, 1'b1, 3'b010, 32'h22, 32'hFFFF_FFFF, 1, rd); idle(1);
        access(1, 1'b0, 3'b011, 32'h20, 32'h0, 1, rd);         idle(1);
        access(1, 1'b1, 3'b100, 32'h20, 32'h0, 1, rd);         idle(1);
        access(1, 1'b0, 3'b010, 32'h20, 32'h0, 3, rd);         idle(1);
        chk("ram_after_faults", rd, 32'hCDEF_AB78);

        // Zero wait states, req held: done every second cycle, 0x1000 aliases 0x0
        access(0, 1'b1, 3'b010, 32'h1000, 32'hA5A5_A5A5, 1, rd);
        access(0, 1'b0, 3'b010, 32'h0000, 32'h0, 2, rd);
        chk("alias_0", rd, 32'hA5A5_A5A5);
        access(0, 1'b1, 3'b010, 32'h0004, 32'h5A5A_0001, 2, rd);
        access(0, 1'b0, 3'b010, 32'h1004, 32'h0, 2, rd);
        chk("alias_4", rd, 32'h5A5A_0001);
        idle(0);

        // Random traffic, aliased addresses, all funct3 codes
        for (int i = 0; i < 60; i++) begin
            a  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            f3 = 3'($urandom_range(0, 7));
            w  = 1'($urandom_range(0, 1));
            access(1, w, f3, a, $urandom, model_bad(w, f3, a) ? 1 : 3, rd);
            idle(1);
        end
        for (int i = 0; i < 60; i++) begin
            a  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            f3 = 3'($urandom_range(0, 7));
            w  = 1'($urandom_range(0, 1));
            access(0, w, f3, a, $urandom, (i == 0) ? 1 : 2, rd);
        end
        idle(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
